oser8_word_source: RTL and testbench

Parallel-word source that feeds an OSER8 serializer, clocked in the serializer's PCLK domain. It accepts 8-bit words over a valid/ready handshake, buffers them in a small FIFO, and presents one word per cycle on the OSER8 D0..D7 inputs together with the TX0..TX3 output-enable controls and the serializer RESET. After reset it holds the serializer in reset, sends a training pattern, then streams payload, filling gaps with an idle word. The OSER8 Q0 output goes to a TLVDS_OBUF pair.

---
 rtl/oser8_pkg.sv | 18 +
 rtl/oser8_word_fifo.sv | 54 +++++
 rtl/oser8_word_source.sv | 158 +++++++++++++++
 tb/tb_oser8_word_source.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/oser8_pkg.sv
// Shared types and constants for the OSER8 word source: FSM states, TX
// enable encodings and the default idle/training words.
package oser8_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // OSER8 TX inputs are active-low output enables
    localparam logic [3:0] TX_DRIVE = 4'h0;
    localparam logic [3:0] TX_HIZ   = 4'hF;

    localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;
    localparam logic [7:0] DEF_TRAIN_WORD = 8'h55;

endpackage

// File: rtl/oser8_word_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two
// so the pointers wrap naturally.
module oser8_word_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    wr_ok;
    logic                    rd_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset: emptying the pointers/count discards contents.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oser8_word_source.sv
// Parallel-word source for an OSER8: HOLD -> TRAIN -> RUN sequencing with a
// word FIFO. Optional underflow counter under OSER8_WORD_SOURCE_STATS_EN.
module oser8_word_source
    import oser8_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter logic [7:0] IDLE_WORD  = DEF_IDLE_WORD,
    parameter logic [7:0] TRAIN_WORD = DEF_TRAIN_WORD,
    parameter int         TRAIN_LEN  = 16,
    parameter int         RST_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       train_i,
    output logic [7:0] d_o,
    output logic [3:0] tx_o,
    output logic       oser_rst_o,
    output logic       training_o,
    output logic       underflow_o
`ifdef OSER8_WORD_SOURCE_STATS_EN
    ,
    output logic [15:0] underflow_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [TW-1:0] train_cnt, train_cnt_n;

    logic       fifo_full, fifo_empty, rd_en, wr_en;
    logic [7:0] fifo_rd_data;
    logic [AW:0] level_unused;

    logic [7:0] d_n;
    logic [3:0] tx_n;
    logic       oser_rst_n, training_n, underflow_n;

    assign wr_en = valid_i && ready_o;

    oser8_word_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en),
        .wr_data (data_i),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (level_unused)
    );

    // State register; the output registers load alongside it so every
    // output is a flop. train_cnt counts TRAIN_WORDs already on d_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            train_cnt   <= '0;
            d_o         <= IDLE_WORD;
            tx_o        <= TX_HIZ;
            oser_rst_o  <= 1'b1;
            training_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_cnt_n;
            train_cnt   <= train_cnt_n;
            d_o         <= d_n;
            tx_o        <= tx_n;
            oser_rst_o  <= oser_rst_n;
            training_o  <= training_n;
            underflow_o <= underflow_n;
        end
    end

    // HOLD's last cycle already emits the first TRAIN_WORD, so the burst
    // continues in TRAIN with one word counted.
    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        train_cnt_n = train_cnt;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n     = (TRAIN_LEN == 1) ? RUN : TRAIN;
                    train_cnt_n = TW'(1);
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            TRAIN: begin
                train_cnt_n = train_cnt + 1'b1;
                if (train_cnt == TRAIN_LAST) state_n = RUN;
            end
            RUN: begin
                if (train_i) begin
                    state_n     = TRAIN;
                    train_cnt_n = '0;
                end
            end
            default: state_n = HOLD;
        endcase
    end

    // Output decode: the word read during a RUN cycle lands on d_o at its
    // closing edge, including the cycle that hands over to TRAIN.
    always_comb begin
        ready_o     = (state != HOLD) && !fifo_full;
        rd_en       = (state == RUN) && !fifo_empty;
        d_n         = IDLE_WORD;
        tx_n        = TX_HIZ;
        oser_rst_n  = 1'b1;
        training_n  = 1'b0;
        underflow_n = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    d_n        = TRAIN_WORD;
                    tx_n       = TX_DRIVE;
                    oser_rst_n = 1'b0;
                    training_n = 1'b1;
                end
            end
            TRAIN: begin
                d_n        = TRAIN_WORD;
                tx_n       = TX_DRIVE;
                oser_rst_n = 1'b0;
                training_n = 1'b1;
            end
            RUN: begin
                d_n         = fifo_empty ? IDLE_WORD : fifo_rd_data;
                underflow_n = fifo_empty;
                tx_n        = TX_DRIVE;
                oser_rst_n  = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef OSER8_WORD_SOURCE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            underflow_cnt_o <= '0;
        else if (underflow_o && underflow_cnt_o != 16'hFFFF)
            underflow_cnt_o <= underflow_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_oser8_word_source.sv
// Randomized/directed bench for oser8_word_source against a queue-based
// reference model; covers OSER8_WORD_SOURCE_STATS_EN when defined.
module tb_oser8_word_source;

    localparam int         DEPTH      = 8;
    localparam int         TRAIN_LEN  = 16;
    localparam int         RST_CYCLES = 4;
    localparam logic [7:0] IDLE       = 8'h00;
    localparam logic [7:0] TRW        = 8'h55;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       train_i = 1'b0;
    logic       ready_o;
    logic [7:0] d_o;
    logic [3:0] tx_o;
    logic       oser_rst_o;
    logic       training_o;
    logic       underflow_o;
`ifdef OSER8_WORD_SOURCE_STATS_EN
    logic [15:0] underflow_cnt_o;
`endif

    oser8_word_source #(
        .DEPTH(DEPTH), .IDLE_WORD(IDLE), .TRAIN_WORD(TRW),
        .TRAIN_LEN(TRAIN_LEN), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .train_i     (train_i),
        .d_o         (d_o),
        .tx_o        (tx_o),
        .oser_rst_o  (oser_rst_o),
        .training_o  (training_o),
        .underflow_o (underflow_o)
`ifdef OSER8_WORD_SOURCE_STATS_EN
        ,
        .underflow_cnt_o (underflow_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining HOLD/TRAIN words plus a queue of accepted words.
    logic [7:0] q[$];
    int         hold_left;
    int         train_left;
    logic [7:0] e_d;
    logic [3:0] e_tx;
    logic       e_orst, e_trn, e_uf, e_rdy, acc;
    int         e_cnt;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic emit(input logic [7:0] d, input logic [3:0] tx, input logic orst,
                        input logic trn, input logic uf);
        e_d = d; e_tx = tx; e_orst = orst; e_trn = trn; e_uf = uf;
    endtask

    task automatic model_reset();
        q.delete();
        hold_left  = RST_CYCLES;
        train_left = 0;
        e_cnt      = 0;
        emit(IDLE, 4'hF, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic running();
        return (hold_left == 0) && (train_left == 0);
    endfunction

    task automatic check_outputs(input string ph);
        chk({ph, ".d"},        {8'h0, d_o},         {8'h0, e_d});
        chk({ph, ".tx"},       {12'h0, tx_o},       {12'h0, e_tx});
        chk({ph, ".oser_rst"}, {15'h0, oser_rst_o}, {15'h0, e_orst});
        chk({ph, ".training"}, {15'h0, training_o}, {15'h0, e_trn});
        chk({ph, ".underflow"},{15'h0, underflow_o},{15'h0, e_uf});
`ifdef OSER8_WORD_SOURCE_STATS_EN
        chk({ph, ".uf_cnt"},   underflow_cnt_o,     16'(e_cnt));
`endif
    endtask

    // One clock: check ready, advance the model, then check registered outputs.
    task automatic tick(input string ph);
        e_rdy = (hold_left == 0) && (q.size() < DEPTH);
        chk({ph, ".ready"}, {15'h0, ready_o}, {15'h0, e_rdy});
        acc = valid_i && e_rdy;
        if (e_uf && e_cnt < 65535) e_cnt++;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
                emit(TRW, 4'h0, 1'b0, 1'b1, 1'b0);
                train_left = TRAIN_LEN - 1;
            end else begin
                emit(IDLE, 4'hF, 1'b1, 1'b0, 1'b0);
            end
        end else if (train_left > 0) begin
            emit(TRW, 4'h0, 1'b0, 1'b1, 1'b0);
            train_left--;
        end else begin
            if (q.size() > 0) emit(q.pop_front(), 4'h0, 1'b0, 1'b0, 1'b0);
            else              emit(IDLE, 4'h0, 1'b0, 1'b0, 1'b1);
            if (train_i) train_left = TRAIN_LEN;
        end
        if (acc) q.push_back(data_i);
        @(posedge clk_i);
        #1;
        check_outputs(ph);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("rst");
        chk("rst.ready", {15'h0, ready_o}, 16'h0);
        rst_i = 1'b0;

        // Startup: hold, training burst, then idle fill.
        repeat (RST_CYCLES + TRAIN_LEN + 4) tick("startup");

        // Three back-to-back words.
        for (int i = 1; i <= 3; i++) begin
            valid_i = 1'b1; data_i = 8'(i); tick("burst");
        end
        valid_i = 1'b0;
        repeat (4) tick("burst_tail");

        // Fill the FIFO while training so it goes full, then drain.
        train_i = 1'b1; tick("fill_pulse"); train_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h10;
        repeat (TRAIN_LEN + 12) begin
            acc = ready_o;
            tick("fill");
            if (acc) data_i = data_i + 8'd1;
        end
        valid_i = 1'b0;
        repeat (12) tick("drain");

        // Queue words during training, then pulse train_i in the first RUN cycle.
        train_i = 1'b1; tick("q_pulse"); train_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; data_i = 8'hA0 + 8'(i); tick("q_load");
        end
        valid_i = 1'b0;
        for (int k = 0; k < 2 * TRAIN_LEN && !running(); k++) tick("q_wait");
        train_i = 1'b1; tick("retrain"); train_i = 1'b0;
        repeat (TRAIN_LEN + 10) tick("retrain_tail");

        // Held-high train_i alternates one RUN cycle with a burst.
        train_i = 1'b1; valid_i = 1'b1; data_i = 8'h77;
        repeat (3 * TRAIN_LEN) tick("train_held");
        train_i = 1'b0; valid_i = 1'b0;
        repeat (12) tick("train_held_tail");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = 8'($urandom);
            train_i = ($urandom_range(0, 49) == 0);
            tick("rand");
        end
        train_i = 1'b0;

        // Asynchronous reset mid-RUN with words queued.
        train_i = 1'b1; tick("r_pulse"); train_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 8'hC0 + 8'(i); tick("r_load");
        end
        valid_i = 1'b0;
        for (int k = 0; k < 2 * TRAIN_LEN && !running(); k++) tick("r_wait");
        tick("r_run");
        rst_i = 1'b1;
        #2;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.ready", {15'h0, ready_o}, 16'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (RST_CYCLES + TRAIN_LEN + 10) tick("post_rst");

`ifdef OSER8_WORD_SOURCE_STATS_EN
        repeat (70000) tick("stats");
        chk("stats.saturated", underflow_cnt_o, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
